// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor leaf cell: combinational a - b - bin for ripple-borrow
// chaining, plus a valid-qualified registered copy and a saturating borrow counter.
module full_subtractor_1bit #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             bin,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             diff,
    output logic             bout,
    output logic             diff_q,
    output logic             bout_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Borrow-chain path: no clock or reset dependence
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

    generate
        if (REG_OUT != 0) begin : g_reg
            logic diff_r;
            logic bout_r;
            logic valid_r;

            // Result registers hold across invalid cycles; valid drops
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_r  <= 1'b0;
                    bout_r  <= 1'b0;
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= in_valid;
                    if (in_valid) begin
                        diff_r <= diff;
                        bout_r <= bout;
                    end
                end
            end

            assign diff_q    = diff_r;
            assign bout_q    = bout_r;
            assign out_valid = valid_r;
        end else begin : g_comb
            assign diff_q    = diff;
            assign bout_q    = bout;
            assign out_valid = in_valid;
        end
    endgenerate

    logic [CNT_W-1:0] cnt_r;

    // Saturating borrow-event counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (in_valid && bout && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign borrow_cnt = cnt_r;

endmodule

// File: tb/tb_full_subtractor_1bit.sv
// Directed self-checking bench for full_subtractor_1bit: truth table, ripple chain,
// valid gating, async reset, REG_OUT=0 bypass and counter saturation/clear.
`timescale 1ns/1ps
module tb_full_subtractor_1bit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance (CNT_W=8, REG_OUT=1)
    logic a, b, bin, in_valid, cnt_clr;
    logic diff, bout, diff_q, bout_q, out_valid;
    logic [7:0] borrow_cnt;

    full_subtractor_1bit #(.CNT_W(8), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .diff(diff), .bout(bout), .diff_q(diff_q), .bout_q(bout_q),
        .out_valid(out_valid), .borrow_cnt(borrow_cnt)
    );

    // Bypass instance sharing the main inputs
    logic z_diff, z_bout, z_diff_q, z_bout_q, z_out_valid;
    logic [7:0] z_cnt;

    full_subtractor_1bit #(.CNT_W(8), .REG_OUT(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .diff(z_diff), .bout(z_bout), .diff_q(z_diff_q), .bout_q(z_bout_q),
        .out_valid(z_out_valid), .borrow_cnt(z_cnt)
    );

    // Narrow-counter instance for saturation
    logic s_a, s_b, s_bin, s_valid, s_clr;
    logic s_diff, s_bout, s_diff_q, s_bout_q, s_out_valid;
    logic [1:0] s_cnt;

    full_subtractor_1bit #(.CNT_W(2), .REG_OUT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(s_a), .b(s_b), .bin(s_bin),
        .in_valid(s_valid), .cnt_clr(s_clr),
        .diff(s_diff), .bout(s_bout), .diff_q(s_diff_q), .bout_q(s_bout_q),
        .out_valid(s_out_valid), .borrow_cnt(s_cnt)
    );

    // 8-bit ripple-borrow chain
    logic [7:0] ca, cb, cd, cdq, cbq, cov;
    logic       cin;
    logic [8:0] cborrow;
    logic [7:0] ccnt [8];
    assign cborrow[0] = cin;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_chain
            full_subtractor_1bit #(.CNT_W(8), .REG_OUT(1)) u_cell (
                .clk(clk), .rst_n(rst_n), .a(ca[g]), .b(cb[g]), .bin(cborrow[g]),
                .in_valid(1'b0), .cnt_clr(1'b0),
                .diff(cd[g]), .bout(cborrow[g+1]), .diff_q(cdq[g]), .bout_q(cbq[g]),
                .out_valid(cov[g]), .borrow_cnt(ccnt[g])
            );
        end
    endgenerate

    logic [7:0] exp_cnt;

    task automatic test_reset();
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; bin = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
        s_a = 1'b0; s_b = 1'b0; s_bin = 1'b0; s_valid = 1'b0; s_clr = 1'b0;
        ca = 8'h00; cb = 8'h00; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({diff_q, bout_q, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_regs: got %b expected 000", {diff_q, bout_q, out_valid});
        end
        n_checks++;
        if (borrow_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", borrow_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_valid: got %b expected 0", out_valid);
        end
        exp_cnt = 8'd0;
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_d;
        logic [7:0] exp_b;
        exp_d = 8'b1001_0110;
        exp_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a, b, bin} = 3'(i);
            in_valid = 1'b1;
            #1;
            n_checks++;
            if ({diff, bout} !== {exp_d[i], exp_b[i]}) begin
                n_fail++;
                $display("FAIL tt_comb[%0d]: got d%b b%b expected d%b b%b",
                         i, diff, bout, exp_d[i], exp_b[i]);
            end
            @(posedge clk); #1;
            if (exp_b[i]) exp_cnt = exp_cnt + 8'd1;
            n_checks++;
            if ({diff_q, bout_q, out_valid} !== {exp_d[i], exp_b[i], 1'b1}) begin
                n_fail++;
                $display("FAIL tt_reg[%0d]: got d%b b%b v%b expected d%b b%b v1",
                         i, diff_q, bout_q, out_valid, exp_d[i], exp_b[i]);
            end
            n_checks++;
            if (borrow_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL tt_cnt[%0d]: got %0d expected %0d", i, borrow_cnt, exp_cnt);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_chain();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vc [4];
        logic [7:0] vr [4];
        logic       vo [4];
        va[0] = 8'h24; vb[0] = 8'h81; vc[0] = 1'b1; vr[0] = 8'hA2; vo[0] = 1'b1;
        va[1] = 8'h09; vb[1] = 8'h03; vc[1] = 1'b0; vr[1] = 8'h06; vo[1] = 1'b0;
        va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b1; vr[2] = 8'hFF; vo[2] = 1'b1;
        va[3] = 8'hFF; vb[3] = 8'hFF; vc[3] = 1'b0; vr[3] = 8'h00; vo[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ca = va[i]; cb = vb[i]; cin = vc[i];
            #1;
            n_checks++;
            if ({cborrow[8], cd} !== {vo[i], vr[i]}) begin
                n_fail++;
                $display("FAIL chain[%0d]: got bout=%b res=%h expected bout=%b res=%h",
                         i, cborrow[8], cd, vo[i], vr[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        @(negedge clk);
        cnt_clr = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b0;
        a = 1'b0; b = 1'b1; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 1'b1; b = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({diff_q, bout_q, out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL gate_hold: got d%b b%b v%b expected d1 b1 v0",
                     diff_q, bout_q, out_valid);
        end
        n_checks++;
        if (borrow_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gate_cnt: got %0d expected 1", borrow_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        a = 1'b0; b = 1'b1; bin = 1'b0; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({borrow_cnt, out_valid} !== {8'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_pre: got cnt=%0d v=%b expected cnt=5 v=1", borrow_cnt, out_valid);
        end
        #2;
        rst_n = 1'b0;
        a = 1'b1; b = 1'b0; bin = 1'b0;
        #1;
        n_checks++;
        if ({diff_q, bout_q, out_valid, borrow_cnt} !== {3'b000, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got d%b b%b v%b cnt=%0d expected all 0",
                     diff_q, bout_q, out_valid, borrow_cnt);
        end
        n_checks++;
        if ({diff, bout} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_comb: got d%b b%b expected d1 b0", diff, bout);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, borrow_cnt} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_release: got v%b cnt=%0d expected v0 cnt=0", out_valid, borrow_cnt);
        end
    endtask

    task automatic test_reg_out0();
        @(negedge clk);
        a = 1'b1; b = 1'b1; bin = 1'b1; in_valid = 1'b1;
        #1;
        n_checks++;
        if ({z_diff_q, z_bout_q, z_out_valid} !== 3'b111) begin
            n_fail++;
            $display("FAIL bypass_on: got d%b b%b v%b expected d1 b1 v1",
                     z_diff_q, z_bout_q, z_out_valid);
        end
        a = 1'b1; b = 1'b0; bin = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({z_diff_q, z_bout_q, z_out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL bypass_off: got d%b b%b v%b expected d0 b0 v0",
                     z_diff_q, z_bout_q, z_out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq [5];
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
        @(negedge clk);
        s_a = 1'b0; s_b = 1'b1; s_bin = 1'b0; s_valid = 1'b1; s_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (s_cnt !== seq[i]) begin
                n_fail++;
                $display("FAIL sat[%0d]: got %0d expected %0d", i, s_cnt, seq[i]);
            end
        end
        @(negedge clk);
        s_clr = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL sat_clr: got %0d expected 0", s_cnt);
        end
        @(negedge clk);
        s_clr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (s_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_after_clr: got %0d expected 1", s_cnt);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_chain();
        test_valid_gating();
        test_reset_midstream();
        test_reg_out0();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
